// File: rtl/pwl_pkg.sv
// Shared constants and the coefficient-pair type for the piecewise-linear evaluator.
// The evaluator's rounding option is selected by the PWL_ROUND_EN macro.
package pwl_pkg;

    localparam int PWL_WI   = 8;
    localparam int PWL_WF   = 8;
    localparam int PWL_NSEG = 16;
    localparam int PWL_W    = PWL_WI + PWL_WF;

    typedef struct packed {
        logic [PWL_W-1:0] slope;
        logic [PWL_W-1:0] icpt;
    } coef_t;

endpackage

// File: rtl/pwl_coef_table.sv
// Coefficient table: one synchronous write port, one combinational read port.
// A read of the entry being written in the same cycle returns the old contents.
module pwl_coef_table
    import pwl_pkg::*;
#(
    parameter int NSEG = PWL_NSEG,
    parameter int AW   = $clog2(NSEG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  coef_t         wdata,
    input  logic [AW-1:0] raddr,
    output coef_t         rdata
);

    coef_t mem [NSEG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/segment_evaluator.sv
// Three-stage piecewise-linear evaluator: y = sat(((x * slope) >>> WF) + icpt).
// Define PWL_ROUND_EN to round half up before the WF shift instead of truncating.
module segment_evaluator
    import pwl_pkg::*;
#(
    parameter int WI   = PWL_WI,
    parameter int WF   = PWL_WF,
    parameter int NSEG = PWL_NSEG,
    localparam int W   = WI + WF,
    localparam int AW  = $clog2(NSEG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  x_in,
    input  logic [5:0]    seg_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  y_out,
    output logic          seg_err,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_slope,
    input  logic [W-1:0]  coef_icpt
);

    // Product of a zero-extended x (W+1 bits) and a signed slope (W bits).
    localparam int PW = 2 * W + 1;
    localparam logic signed [PW:0] MAX_V = {{(PW + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW:0] MIN_V = {{(PW + 2 - W){1'b1}}, {(W - 1){1'b0}}};

    // Handshake: a beat moves on either side only when valid && ready in the same
    // cycle. The whole pipe shares one enable, so a stalled output freezes every
    // stage and back-pressures the input in the same cycle; bubbles stay in place.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic          seg_over;
    logic [AW-1:0] rd_addr;
    coef_t         wr_pair;
    coef_t         rd_pair;

    assign seg_over = {26'd0, seg_in} >= 32'(NSEG);
    assign rd_addr  = seg_over ? AW'(NSEG - 1) : seg_in[AW-1:0];
    assign wr_pair  = {coef_slope, coef_icpt};

    pwl_coef_table #(
        .NSEG (NSEG),
        .AW   (AW)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata (wr_pair),
        .raddr (rd_addr),
        .rdata (rd_pair)
    );

    logic                 v1;
    logic [W-1:0]         x1;
    logic signed [W-1:0]  slope1;
    logic signed [W-1:0]  icpt1;
    logic                 err1;

    logic                 v2;
    logic signed [PW-1:0] prod2;
    logic signed [W-1:0]  icpt2;
    logic                 err2;

    // S1: coefficient fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            x1     <= '0;
            slope1 <= '0;
            icpt1  <= '0;
            err1   <= 1'b0;
        end else if (en) begin
            v1     <= in_valid;
            x1     <= x_in;
            slope1 <= rd_pair.slope;
            icpt1  <= rd_pair.icpt;
            err1   <= seg_over;
        end
    end

    // S2: full-precision multiply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            prod2 <= '0;
            icpt2 <= '0;
            err2  <= 1'b0;
        end else if (en) begin
            v2    <= v1;
            prod2 <= PW'($signed({1'b0, x1})) * PW'(slope1);
            icpt2 <= icpt1;
            err2  <= err1;
        end
    end

    logic signed [PW:0] rnd;
    logic signed [PW:0] prod_ext;
    logic signed [PW:0] shifted;
    logic signed [PW:0] sum;
    logic [W-1:0]       y_next;

    always_comb begin
        rnd = '0;
`ifdef PWL_ROUND_EN
        rnd[WF-1] = 1'b1;
`endif
        prod_ext = $signed({prod2[PW-1], prod2});
        shifted  = (prod_ext + rnd) >>> WF;
        sum      = shifted + $signed({{(PW + 1 - W){icpt2[W-1]}}, icpt2});
        if (sum > MAX_V) begin
            y_next = MAX_V[W-1:0];
        end else if (sum < MIN_V) begin
            y_next = MIN_V[W-1:0];
        end else begin
            y_next = sum[W-1:0];
        end
    end

    // S3: add, round, saturate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            seg_err   <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            y_out     <= y_next;
            seg_err   <= err2;
        end
    end

endmodule
